uart_core_p: RTL and testbench

- Parametrised UART transceiver; successor to the fixed 8-bit serializer/deserializer/FIFO datapath.
- Adds configurable data width, bit period, parity, stop bits and FIFO depth.
- Adds start-bit glitch rejection and sticky error flags for frame, parity and overrun.
- Sits between the serial pins and the control FSM/memory side; the host side is a push/pop FIFO interface.

---
 rtl/uart_core_p_if.sv | 31 +++
 rtl/uart_core_p.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_uart_core_p.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_core_p_if.sv
// Host-side FIFO and status bundle of uart_core_p.
// The core connects through the slave modport; the host side uses master.
interface uart_core_p_if #(
  parameter int unsigned DATA_W = 8
);
  logic              tx_wr;
  logic [DATA_W-1:0] tx_data;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_busy;
  logic              rx_rd;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_full;
  logic              err_clr;
  logic              rx_frame_err;
  logic              rx_parity_err;
  logic              rx_overrun;

  modport master (
    output tx_wr, tx_data, rx_rd, err_clr,
    input  tx_full, tx_empty, tx_busy, rx_data, rx_valid, rx_full,
           rx_frame_err, rx_parity_err, rx_overrun
  );

  modport slave (
    input  tx_wr, tx_data, rx_rd, err_clr,
    output tx_full, tx_empty, tx_busy, rx_data, rx_valid, rx_full,
           rx_frame_err, rx_parity_err, rx_overrun
  );
endinterface

// File: rtl/uart_core_p.sv
// Parametrised UART transceiver: TX/RX FIFOs, TX serializer, RX deserializer
// with start-bit glitch rejection and sticky frame/parity/overrun flags.
module uart_core_p_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp, r_rp;
  logic [W-1:0] r_head;
  logic [AW:0]  w_count;
  logic [AW-1:0] w_rp_nxt;
  logic         w_full, w_empty, w_push, w_pop;

  assign w_full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_empty  = (r_wp == r_rp);
  assign w_push   = i_push && !w_full;
  assign w_pop    = i_pop && !w_empty;
  assign w_count  = r_wp - r_rp;
  assign w_rp_nxt = r_rp[AW-1:0] + AW'(1);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end

  // Head is registered so it holds the last popped word once the FIFO drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_head <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + ONE;
      if (w_pop)  r_rp <= r_rp + ONE;
      if (w_pop && (w_count > ONE))
        r_head <= r_mem[w_rp_nxt];
      else if (w_push && (w_empty || (w_pop && (w_count == ONE))))
        r_head <= i_data;
    end
  end

  assign o_head  = r_head;
  assign o_full  = w_full;
  assign o_empty = w_empty;
endmodule

module uart_core_p #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rcv_bit,
  output logic        xmt_bit,
  uart_core_p_if.slave bus
);
  localparam int unsigned CW  = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int unsigned RCW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW  = $clog2(DATA_W);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [DATA_W-1:0] w_tx_head, w_rx_head;
  logic              w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic              w_tx_pop, w_rx_push;

  uart_core_p_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .i_push(bus.tx_wr), .i_data(bus.tx_data), .i_pop(w_tx_pop),
    .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  // ---------------- transmitter ----------------
  tx_state_t         r_tx_state, w_tx_state_n;
  logic [CW-1:0]     r_tx_cnt, w_tx_cnt_n;
  logic [BW-1:0]     r_tx_bit, w_tx_bit_n;
  logic [DATA_W-1:0] r_tx_sh, w_tx_sh_n;
  logic              r_tx_par, w_tx_par_n;
  logic              r_xmt, w_xmt_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_tx_par   <= 1'b0;
      r_xmt      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_cnt   <= w_tx_cnt_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_sh    <= w_tx_sh_n;
      r_tx_par   <= w_tx_par_n;
      r_xmt      <= w_xmt_n;
    end
  end

  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt + CW'(1);
    w_tx_bit_n   = r_tx_bit;
    w_tx_sh_n    = r_tx_sh;
    w_tx_par_n   = r_tx_par;
    w_tx_pop     = 1'b0;
    w_xmt_n      = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_n = '0;
        if (!w_tx_empty) begin
          w_tx_pop     = 1'b1;
          w_tx_sh_n    = w_tx_head;
          w_tx_par_n   = (PARITY == 1) ? ~^w_tx_head : ^w_tx_head;
          w_tx_state_n = TX_START;
        end
      end
      TX_START: begin
        w_xmt_n = 1'b0;
        if (r_tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_tx_cnt_n   = '0;
          w_tx_bit_n   = '0;
          w_tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        w_xmt_n = r_tx_sh[0];
        if (r_tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_tx_cnt_n = '0;
          w_tx_sh_n  = r_tx_sh >> 1;
          if (r_tx_bit == BW'(DATA_W - 1))
            w_tx_state_n = (PARITY != 0) ? TX_PARITY : TX_STOP;
          else
            w_tx_bit_n = r_tx_bit + BW'(1);
        end
      end
      TX_PARITY: begin
        w_xmt_n = r_tx_par;
        if (r_tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_tx_cnt_n   = '0;
          w_tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == CW'(STOP_BITS * CLKS_PER_BIT - 1)) begin
          w_tx_cnt_n = '0;
          if (!w_tx_empty) begin
            w_tx_pop     = 1'b1;
            w_tx_sh_n    = w_tx_head;
            w_tx_par_n   = (PARITY == 1) ? ~^w_tx_head : ^w_tx_head;
            w_tx_state_n = TX_START;
          end else begin
            w_tx_state_n = TX_IDLE;
          end
        end
      end
      default: w_tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  logic              r_sync1, r_sync2;
  rx_state_t         r_rx_state, w_rx_state_n;
  logic [RCW-1:0]    r_rx_cnt, w_rx_cnt_n;
  logic [BW-1:0]     r_rx_bit, w_rx_bit_n;
  logic [DATA_W-1:0] r_rx_sh, w_rx_sh_n;
  logic              r_rx_par, w_rx_par_n;
  logic              r_ferr, r_perr, r_ovr;
  logic              w_set_f, w_set_p, w_set_o, w_par_bad, w_rx;

  assign w_rx = r_sync2;
  assign w_par_bad = (PARITY == 1) ? (r_rx_par != ~^r_rx_sh) :
                     (PARITY == 2) ? (r_rx_par != ^r_rx_sh)  : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_par   <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_sync1    <= rcv_bit;
      r_sync2    <= r_sync1;
      r_rx_state <= w_rx_state_n;
      r_rx_cnt   <= w_rx_cnt_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_sh    <= w_rx_sh_n;
      r_rx_par   <= w_rx_par_n;
      r_ferr     <= w_set_f | (r_ferr & ~bus.err_clr);
      r_perr     <= w_set_p | (r_perr & ~bus.err_clr);
      r_ovr      <= w_set_o | (r_ovr & ~bus.err_clr);
    end
  end

  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n   = r_rx_cnt + RCW'(1);
    w_rx_bit_n   = r_rx_bit;
    w_rx_sh_n    = r_rx_sh;
    w_rx_par_n   = r_rx_par;
    w_rx_push    = 1'b0;
    w_set_f      = 1'b0;
    w_set_p      = 1'b0;
    w_set_o      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_n = '0;
        if (!w_rx) w_rx_state_n = RX_START;
      end
      RX_START: begin
        if (r_rx_cnt == RCW'(CLKS_PER_BIT / 2 - 1)) begin
          w_rx_cnt_n   = '0;
          w_rx_bit_n   = '0;
          w_rx_state_n = w_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == RCW'(CLKS_PER_BIT - 1)) begin
          w_rx_cnt_n = '0;
          w_rx_sh_n  = {w_rx, r_rx_sh[DATA_W-1:1]};
          if (r_rx_bit == BW'(DATA_W - 1))
            w_rx_state_n = (PARITY != 0) ? RX_PARITY : RX_STOP;
          else
            w_rx_bit_n = r_rx_bit + BW'(1);
        end
      end
      RX_PARITY: begin
        if (r_rx_cnt == RCW'(CLKS_PER_BIT - 1)) begin
          w_rx_cnt_n   = '0;
          w_rx_par_n   = w_rx;
          w_rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        // A parity error discards the word but the stop bit is still judged.
        if (r_rx_cnt == RCW'(CLKS_PER_BIT - 1)) begin
          w_rx_cnt_n = '0;
          w_set_p    = w_par_bad;
          if (w_rx) begin
            if (!w_par_bad) begin
              if (w_rx_full) w_set_o   = 1'b1;
              else           w_rx_push = 1'b1;
            end
            w_rx_state_n = RX_IDLE;
          end else begin
            w_set_f      = 1'b1;
            w_rx_state_n = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        w_rx_cnt_n = '0;
        if (w_rx) w_rx_state_n = RX_IDLE;
      end
      default: w_rx_state_n = RX_IDLE;
    endcase
  end

  uart_core_p_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .i_push(w_rx_push), .i_data(r_rx_sh), .i_pop(bus.rx_rd),
    .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  assign xmt_bit           = r_xmt;
  assign bus.tx_full       = w_tx_full;
  assign bus.tx_empty      = w_tx_empty;
  assign bus.tx_busy       = (r_tx_state != TX_IDLE);
  assign bus.rx_data       = w_rx_head;
  assign bus.rx_valid      = !w_rx_empty;
  assign bus.rx_full       = w_rx_full;
  assign bus.rx_frame_err  = r_ferr;
  assign bus.rx_parity_err = r_perr;
  assign bus.rx_overrun    = r_ovr;
endmodule

// File: tb/tb_uart_core_p.sv
// Directed bench for uart_core_p: instance A (even parity) driven by hand,
// instance B (odd parity) looped back xmt_bit -> rcv_bit.
module tb_uart_core_p;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rcv_a = 1'b1;
  logic xmt_a, xmt_b;
  int n_checks = 0;
  int n_fail = 0;

  uart_core_p_if #(.DATA_W(8)) bus_a ();
  uart_core_p_if #(.DATA_W(8)) bus_b ();

  uart_core_p #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .rcv_bit(rcv_a), .xmt_bit(xmt_a), .bus(bus_a)
  );

  uart_core_p #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_odd (
    .clk(clk), .rst(rst), .rcv_bit(xmt_b), .xmt_bit(xmt_b), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_a(input logic [7:0] d);
    bus_a.tx_wr = 1'b1;
    bus_a.tx_data = d;
    tick();
    bus_a.tx_wr = 1'b0;
  endtask

  task automatic pop_a();
    bus_a.rx_rd = 1'b1;
    tick();
    bus_a.rx_rd = 1'b0;
  endtask

  task automatic pop_b();
    bus_b.rx_rd = 1'b1;
    tick();
    bus_b.rx_rd = 1'b0;
  endtask

  task automatic clr_a();
    bus_a.err_clr = 1'b1;
    tick();
    bus_a.err_clr = 1'b0;
  endtask

  // Called at the negedge following the write edge n.
  task automatic check_tx_frame(input logic [7:0] d, input logic par);
    logic exp;
    int b;
    tick();
    check("tx_latency_high", xmt_a, 1'b1);
    for (int k = 0; k < 44; k++) begin
      tick();
      b = k / 4;
      if (b == 0) exp = 1'b0;
      else if (b <= 8) exp = d[b-1];
      else if (b == 9) exp = par;
      else exp = 1'b1;
      check($sformatf("tx_bit_k%0d", k), xmt_a, exp);
      if (k % 4 == 1) check($sformatf("tx_busy_k%0d", k), bus_a.tx_busy, 1'b1);
    end
    tick();
    check("tx_idle_after", xmt_a, 1'b1);
    check("tx_busy_after", bus_a.tx_busy, 1'b0);
  endtask

  task automatic send_frame_a(input logic [7:0] d, input logic par, input logic stp);
    rcv_a = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      rcv_a = d[i];
      repeat (4) tick();
    end
    rcv_a = par;
    repeat (4) tick();
    rcv_a = stp;
    repeat (4) tick();
    rcv_a = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    int busy_cnt;
    logic [7:0] rxw;
    bus_a.tx_wr = 0; bus_a.tx_data = '0; bus_a.rx_rd = 0; bus_a.err_clr = 0;
    bus_b.tx_wr = 0; bus_b.tx_data = '0; bus_b.rx_rd = 0; bus_b.err_clr = 0;

    repeat (3) @(negedge clk);
    check("rst_xmt", xmt_a, 1'b1);
    check("rst_tx_empty", bus_a.tx_empty, 1'b1);
    check("rst_tx_full", bus_a.tx_full, 1'b0);
    check("rst_tx_busy", bus_a.tx_busy, 1'b0);
    check("rst_rx_valid", bus_a.rx_valid, 1'b0);
    check("rst_rx_full", bus_a.rx_full, 1'b0);
    check("rst_errs", {bus_a.rx_frame_err, bus_a.rx_parity_err, bus_a.rx_overrun}, 3'b000);
    check("rst_rx_data", bus_a.rx_data, 8'h00);
    rst = 1'b1;
    tick();

    // Single frame, even parity of 0xA5 is 0.
    push_a(8'hA5);
    check_tx_frame(8'hA5, 1'b0);

    // Loopback, odd parity, three back-to-back frames.
    bus_b.tx_wr = 1'b1; bus_b.tx_data = 8'h00; tick();
    bus_b.tx_data = 8'hFF; tick();
    bus_b.tx_data = 8'h3C; tick();
    bus_b.tx_wr = 1'b0;
    for (int k = 0; k < 132; k++) begin
      if (k == 0)  check("lb_start0", xmt_b, 1'b0);
      if (k == 6)  check("lb_f0_bit0", xmt_b, 1'b0);
      if (k == 38) check("lb_f0_par", xmt_b, 1'b1);
      if (k == 43) begin check("lb_stop0", xmt_b, 1'b1); check("lb_busy0", bus_b.tx_busy, 1'b1); end
      if (k == 44) check("lb_start1_nogap", xmt_b, 1'b0);
      if (k == 50) check("lb_f1_bit0", xmt_b, 1'b1);
      if (k == 87) begin check("lb_stop1", xmt_b, 1'b1); check("lb_busy1", bus_b.tx_busy, 1'b1); end
      if (k == 88) check("lb_start2_nogap", xmt_b, 1'b0);
      tick();
    end
    repeat (20) tick();
    check("lb_valid", bus_b.rx_valid, 1'b1);
    check("lb_w0", bus_b.rx_data, 8'h00); pop_b();
    check("lb_w1", bus_b.rx_data, 8'hFF); pop_b();
    check("lb_w2", bus_b.rx_data, 8'h3C); pop_b();
    check("lb_empty", bus_b.rx_valid, 1'b0);
    check("lb_errs", {bus_b.rx_frame_err, bus_b.rx_parity_err, bus_b.rx_overrun}, 3'b000);

    // Framing error then recovery.
    send_frame_a(8'h5A, 1'b0, 1'b0);
    check("fe_flag", bus_a.rx_frame_err, 1'b1);
    check("fe_no_push", bus_a.rx_valid, 1'b0);
    check("fe_no_perr", bus_a.rx_parity_err, 1'b0);
    send_frame_a(8'h11, 1'b0, 1'b1);
    check("fe_next_valid", bus_a.rx_valid, 1'b1);
    check("fe_next_data", bus_a.rx_data, 8'h11);
    check("fe_sticky", bus_a.rx_frame_err, 1'b1);
    pop_a();
    clr_a();
    check("fe_cleared", bus_a.rx_frame_err, 1'b0);

    // Parity error: 0x03 even parity is 0, send 1.
    send_frame_a(8'h03, 1'b1, 1'b1);
    check("pe_flag", bus_a.rx_parity_err, 1'b1);
    check("pe_no_push", bus_a.rx_valid, 1'b0);
    check("pe_no_ferr", bus_a.rx_frame_err, 1'b0);
    clr_a();
    check("pe_cleared", bus_a.rx_parity_err, 1'b0);

    // RX overrun with depth 4; parities of 0x10..0x14 are 1,0,0,1,0.
    send_frame_a(8'h10, 1'b1, 1'b1);
    send_frame_a(8'h11, 1'b0, 1'b1);
    send_frame_a(8'h12, 1'b0, 1'b1);
    send_frame_a(8'h13, 1'b1, 1'b1);
    check("ov_not_yet", bus_a.rx_overrun, 1'b0);
    send_frame_a(8'h14, 1'b0, 1'b1);
    check("ov_full", bus_a.rx_full, 1'b1);
    check("ov_flag", bus_a.rx_overrun, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rxw = 8'h10 + 8'(i);
      check($sformatf("ov_word%0d", i), bus_a.rx_data, rxw);
      pop_a();
    end
    check("ov_drained", bus_a.rx_valid, 1'b0);
    check("ov_hold_data", bus_a.rx_data, 8'h13);
    clr_a();
    check("ov_cleared", bus_a.rx_overrun, 1'b0);

    // TX FIFO overflow: 6 writes, one in flight + 4 queued, 6th dropped.
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      bus_a.tx_wr = 1'b1;
      bus_a.tx_data = 8'h20 + 8'(i);
      tick();
      if (bus_a.tx_busy) busy_cnt++;
      if (i >= 4) check($sformatf("txf_full%0d", i), bus_a.tx_full, 1'b1);
    end
    bus_a.tx_wr = 1'b0;
    for (int i = 0; i < 294; i++) begin
      tick();
      if (bus_a.tx_busy) busy_cnt++;
    end
    check("txf_busy_cycles", busy_cnt, 220);
    check("txf_empty_end", bus_a.tx_empty, 1'b1);

    // One-clock glitch on rcv_bit.
    rcv_a = 1'b0;
    tick();
    rcv_a = 1'b1;
    repeat (20) tick();
    check("gl_no_frame", bus_a.rx_valid, 1'b0);
    check("gl_no_errs", {bus_a.rx_frame_err, bus_a.rx_parity_err, bus_a.rx_overrun}, 3'b000);

    // Reset during data bit 0 of 0x5A (line low), with a second word queued.
    push_a(8'h5A);
    push_a(8'h77);
    repeat (5) tick();
    check("mr_pre_low", xmt_a, 1'b0);
    check("mr_pre_queued", bus_a.tx_empty, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("mr_xmt_high", xmt_a, 1'b1);
    check("mr_tx_empty", bus_a.tx_empty, 1'b1);
    check("mr_tx_busy", bus_a.tx_busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("mr_still_idle", xmt_a, 1'b1);
    push_a(8'hA5);
    check_tx_frame(8'hA5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
